// File: rtl/sdpram_pkg.sv
// rtl/sdpram_pkg.sv - shared constants, init FSM states and parameter check for sdpram_pipe
package sdpram_pkg;

  localparam int RD_MODE_READ_FIRST  = 0;
  localparam int RD_MODE_WRITE_FIRST = 1;

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } init_state_e;

  // Legal parameter combinations: whole byte lanes, latency 1..3, depth fits the address.
  function automatic bit params_ok(input int data_w, input int byte_w, input int rd_lat,
                                   input int depth, input int addr_w);
    return (byte_w > 0) && (data_w % byte_w == 0) &&
           (rd_lat >= 1) && (rd_lat <= 3) &&
           (depth >= 1) && (depth <= (1 << addr_w));
  endfunction

endpackage

// File: rtl/sdpram_pipe_if.sv
// rtl/sdpram_pipe_if.sv - write/read port bundle of sdpram_pipe
interface sdpram_pipe_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_W     = 8
);
  localparam int NBE = DATA_WIDTH / BYTE_W;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NBE-1:0]        wr_be;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  init_done;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  rd_data, rd_valid, init_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output rd_data, rd_valid, init_done
  );
endinterface

// File: rtl/sdpram_init_seq.sv
// rtl/sdpram_init_seq.sv - post-reset sweep that writes every entry once before the RAM opens
module sdpram_init_seq
  import sdpram_pkg::*;
#(
  parameter int ADDR_WIDTH    = 4,
  parameter int DEPTH         = 16,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_we_o,
  output logic [ADDR_WIDTH-1:0] init_addr_o,
  output logic                  init_done_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  init_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  // State and sweep address registers; reset always restarts the sweep from entry 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: one RST cycle, then exactly DEPTH sweep writes, then RUN forever
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    init_we_o = 1'b0;
    case (state_q)
      ST_RST: begin
        cnt_d   = '0;
        state_d = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
      end
      ST_INIT: begin
        init_we_o = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: state_d = ST_RST;
    endcase
  end

  assign init_addr_o = cnt_q;
  assign init_done_o = (state_q == ST_RUN);

endmodule

// File: rtl/sdpram_pipe.sv
// rtl/sdpram_pipe.sv - simple dual-port RAM with byte enables, pipelined reads and init sweep
module sdpram_pipe
  import sdpram_pkg::*;
#(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 2 ** ADDR_WIDTH,
  parameter int BYTE_W        = 8,
  parameter int RD_LATENCY    = 1,
  parameter int RD_MODE       = 1,
  parameter int INIT_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic         clk,
  input  logic         rst,
  sdpram_pipe_if.slave bus
);

  localparam int NBE = DATA_WIDTH / BYTE_W;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  if (!params_ok(DATA_WIDTH, BYTE_W, RD_LATENCY, DEPTH, ADDR_WIDTH)) begin : g_param_check
    $error("sdpram_pipe: illegal parameter combination");
  end

  logic                  init_we;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  init_done;

  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [NBE-1:0]        mem_be;

  logic                  wr_ok;
  logic                  rd_in_range;
  logic                  rd_fire;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [RD_LATENCY-1:0] vld_q;
  logic [DATA_WIDTH-1:0] dat_q [RD_LATENCY];

  sdpram_init_seq #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .DEPTH         (DEPTH),
    .INIT_ON_RESET (INIT_ON_RESET)
  ) u_init_seq (
    .clk         (clk),
    .rst         (rst),
    .init_we_o   (init_we),
    .init_addr_o (init_addr),
    .init_done_o (init_done)
  );

  assign wr_ok       = init_done && bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_W);
  assign rd_in_range = {1'b0, bus.rd_addr} < DEPTH_W;
  assign rd_fire     = init_done && bus.rd_en;

  // Write port owner: the sweep until init completes, the user afterwards
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    mem_be   = '0;
    if (init_done) begin
      mem_we   = wr_ok;
      mem_addr = bus.wr_addr;
      mem_data = bus.wr_data;
      mem_be   = bus.wr_be;
    end else begin
      mem_we   = init_we;
      mem_addr = init_addr;
      mem_data = INIT_VALUE;
      mem_be   = '1;
    end
  end

  // Byte-lane write into the array; unselected lanes keep their contents
  always_ff @(posedge clk) begin
    for (int k = 0; k < NBE; k++) begin
      if (mem_we && mem_be[k]) begin
        mem_q[mem_addr][k*BYTE_W +: BYTE_W] <= mem_data[k*BYTE_W +: BYTE_W];
      end
    end
  end

  // Stage-1 read word: out-of-range reads give 0, write-first forwards the enabled lanes
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem_q[bus.rd_addr];
      if (RD_MODE == RD_MODE_WRITE_FIRST && wr_ok && bus.wr_addr == bus.rd_addr) begin
        for (int k = 0; k < NBE; k++) begin
          if (bus.wr_be[k]) begin
            rd_word[k*BYTE_W +: BYTE_W] = bus.wr_data[k*BYTE_W +: BYTE_W];
          end
        end
      end
    end
  end

  // Read pipeline: data registers only load behind a valid word, so the output holds between pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= rd_fire;
      if (rd_fire) begin
        dat_q[0] <= rd_word;
      end
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

  assign bus.rd_data   = dat_q[RD_LATENCY-1];
  assign bus.rd_valid  = vld_q[RD_LATENCY-1];
  assign bus.init_done = init_done;

endmodule

// File: tb/tb_sdpram_pipe.sv
// tb/tb_sdpram_pipe.sv - self-checking bench for sdpram_pipe across three parameter sets
module tb_sdpram_pipe;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_en;
  logic [3:0]  rd_addr;

  sdpram_pipe_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_W(8)) bus0 ();
  sdpram_pipe_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_W(8)) bus1 ();
  sdpram_pipe_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_W(8)) bus2 ();

  assign bus0.wr_en = wr_en;  assign bus0.wr_addr = wr_addr; assign bus0.wr_data = wr_data;
  assign bus0.wr_be = wr_be;  assign bus0.rd_en   = rd_en;   assign bus0.rd_addr = rd_addr;
  assign bus1.wr_en = wr_en;  assign bus1.wr_addr = wr_addr; assign bus1.wr_data = wr_data;
  assign bus1.wr_be = wr_be;  assign bus1.rd_en   = rd_en;   assign bus1.rd_addr = rd_addr;
  assign bus2.wr_en = wr_en;  assign bus2.wr_addr = wr_addr; assign bus2.wr_data = wr_data;
  assign bus2.wr_be = wr_be;  assign bus2.rd_en   = rd_en;   assign bus2.rd_addr = rd_addr;

  sdpram_pipe #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(16), .BYTE_W(8), .RD_LATENCY(1),
                .RD_MODE(1), .INIT_ON_RESET(1), .INIT_VALUE(32'hA5A5A5A5))
    u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  sdpram_pipe #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(16), .BYTE_W(8), .RD_LATENCY(2),
                .RD_MODE(0), .INIT_ON_RESET(1), .INIT_VALUE(32'h0))
    u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  sdpram_pipe #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(12), .BYTE_W(8), .RD_LATENCY(3),
                .RD_MODE(1), .INIT_ON_RESET(1), .INIT_VALUE(32'h0))
    u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  logic [31:0] o_data  [3];
  logic        o_valid [3];
  logic        o_done  [3];
  assign o_data[0] = bus0.rd_data; assign o_valid[0] = bus0.rd_valid; assign o_done[0] = bus0.init_done;
  assign o_data[1] = bus1.rd_data; assign o_valid[1] = bus1.rd_valid; assign o_done[1] = bus1.init_done;
  assign o_data[2] = bus2.rd_data; assign o_valid[2] = bus2.rd_valid; assign o_done[2] = bus2.init_done;

  // Reference model: array contents, edges since reset release, and read results keyed by due cycle
  int          lat   [3];
  int          depth [3];
  int          mode  [3];
  logic [31:0] initv [3];
  logic [31:0] m_mem [3][16];
  int          run_cnt [3];
  logic        slot_v [3][8];
  logic [31:0] slot_d [3][8];
  logic [31:0] last_d [3];
  int          cyc;

  logic        got   [3];
  logic [31:0] pdat  [3];

  int n_chk;
  int n_fail;

  typedef struct {
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_chk++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, got_v, exp_v);
    end
  endtask

  function automatic logic model_done(input int j);
    return run_cnt[j] >= depth[j] + 1;
  endfunction

  task automatic model_step();
    logic [31:0] v;
    logic        done_b;
    for (int j = 0; j < 3; j++) begin
      done_b = model_done(j);
      if (rst) begin
        run_cnt[j] = 0;
        last_d[j]  = 32'h0;
        for (int s = 0; s < 8; s++) slot_v[j][s] = 1'b0;
      end else begin
        if (done_b && rd_en) begin
          if (int'(rd_addr) >= depth[j]) begin
            v = 32'h0;
          end else begin
            v = m_mem[j][rd_addr];
            if (mode[j] == 1 && wr_en && wr_addr == rd_addr)
              for (int k = 0; k < 4; k++)
                if (wr_be[k]) v[k*8 +: 8] = wr_data[k*8 +: 8];
          end
          slot_v[j][(cyc + lat[j]) % 8] = 1'b1;
          slot_d[j][(cyc + lat[j]) % 8] = v;
        end
        if (done_b && wr_en && int'(wr_addr) < depth[j])
          for (int k = 0; k < 4; k++)
            if (wr_be[k]) m_mem[j][wr_addr][k*8 +: 8] = wr_data[k*8 +: 8];
        if (run_cnt[j] < 1000) run_cnt[j]++;
        if (run_cnt[j] == depth[j] + 1)
          for (int a = 0; a < 16; a++) m_mem[j][a] = initv[j];
      end
    end
    cyc++;
  endtask

  task automatic check_outputs();
    logic ev;
    for (int j = 0; j < 3; j++) begin
      ev = slot_v[j][cyc % 8];
      if (ev) begin
        last_d[j] = slot_d[j][cyc % 8];
        slot_v[j][cyc % 8] = 1'b0;
      end
      chk($sformatf("cyc%0d_dut%0d_init_done", cyc, j), 32'(o_done[j]), 32'(model_done(j)));
      chk($sformatf("cyc%0d_dut%0d_rd_valid", cyc, j), 32'(o_valid[j]), 32'(ev));
      chk($sformatf("cyc%0d_dut%0d_rd_data", cyc, j), o_data[j], last_d[j]);
      if (o_valid[j]) begin
        got[j]  = 1'b1;
        pdat[j] = o_data[j];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = 4'd0; wr_data = 32'h0; wr_be = 4'h0;
    rd_en = 1'b0; rd_addr = 4'd0;
  endtask

  task automatic count_init(input string nm);
    int n;
    n = 0;
    while (!o_done[0] && n < 40) begin
      tick();
      n++;
    end
    chk(nm, 32'(n), 32'd17);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    lat[0] = 1; depth[0] = 16; mode[0] = 1; initv[0] = 32'hA5A5A5A5;
    lat[1] = 2; depth[1] = 16; mode[1] = 0; initv[1] = 32'h0;
    lat[2] = 3; depth[2] = 12; mode[2] = 1; initv[2] = 32'h0;
    for (int j = 0; j < 3; j++) begin
      run_cnt[j] = 0; last_d[j] = 32'h0; got[j] = 1'b0; pdat[j] = 32'h0;
      for (int s = 0; s < 8; s++) begin slot_v[j][s] = 1'b0; slot_d[j][s] = 32'h0; end
      for (int a = 0; a < 16; a++) m_mem[j][a] = 32'h0;
    end

    //                wr  addr   wr_data        be    rd  addr   dut0           dut1           dut2
    vecs[0]  = '{1'b1, 4'd3,  32'h11223344, 4'hF, 1'b0, 4'd0,  32'h0,         32'h0,         32'h0};
    vecs[1]  = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd3,  32'h11223344,  32'h11223344,  32'h11223344};
    vecs[2]  = '{1'b1, 4'd5,  32'hFFFFFFFF, 4'hF, 1'b0, 4'd0,  32'h0,         32'h0,         32'h0};
    vecs[3]  = '{1'b1, 4'd5,  32'h00000000, 4'h5, 1'b0, 4'd0,  32'h0,         32'h0,         32'h0};
    vecs[4]  = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd5,  32'hFF00FF00,  32'hFF00FF00,  32'hFF00FF00};
    vecs[5]  = '{1'b1, 4'd7,  32'hDEADBEEF, 4'hF, 1'b0, 4'd0,  32'h0,         32'h0,         32'h0};
    vecs[6]  = '{1'b1, 4'd7,  32'h12345678, 4'hF, 1'b1, 4'd7,  32'h12345678,  32'hDEADBEEF,  32'h12345678};
    vecs[7]  = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd7,  32'h12345678,  32'h12345678,  32'h12345678};
    vecs[8]  = '{1'b1, 4'd7,  32'hDEADBEEF, 4'hF, 1'b0, 4'd0,  32'h0,         32'h0,         32'h0};
    vecs[9]  = '{1'b1, 4'd7,  32'h12345678, 4'h3, 1'b1, 4'd7,  32'hDEAD5678,  32'hDEADBEEF,  32'hDEAD5678};
    vecs[10] = '{1'b1, 4'd14, 32'h00000055, 4'hF, 1'b0, 4'd0,  32'h0,         32'h0,         32'h0};
    vecs[11] = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd14, 32'h00000055,  32'h00000055,  32'h0};
    vecs[12] = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd0,  32'hA5A5A5A5,  32'h0,         32'h0};
    vecs[13] = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd15, 32'hA5A5A5A5,  32'h0,         32'h0};
    vecs[14] = '{1'b1, 4'd3,  32'hFFFFFFFF, 4'h0, 1'b0, 4'd0,  32'h0,         32'h0,         32'h0};
    vecs[15] = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd3,  32'h11223344,  32'h11223344,  32'h11223344};

    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("reset_dut%0d_rd_data", j), o_data[j], 32'h0);
      chk($sformatf("reset_dut%0d_rd_valid", j), 32'(o_valid[j]), 32'h0);
      chk($sformatf("reset_dut%0d_init_done", j), 32'(o_done[j]), 32'h0);
    end

    // Release reset with reads requested throughout the sweep
    rst = 1'b0;
    rd_en = 1'b1;
    rd_addr = 4'd0;
    count_init("init_sweep_cycles");
    idle_inputs();
    tick();

    // Directed vectors: one request cycle, then enough idle cycles for the slowest pipeline
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 3; j++) got[j] = 1'b0;
      wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
      wr_be = vecs[i].wr_be; rd_en = vecs[i].rd_en; rd_addr = vecs[i].rd_addr;
      tick();
      idle_inputs();
      tick(); tick(); tick();
      if (vecs[i].rd_en) begin
        chk($sformatf("vec%0d_dut0_pulse", i), 32'(got[0]), 32'h1);
        chk($sformatf("vec%0d_dut1_pulse", i), 32'(got[1]), 32'h1);
        chk($sformatf("vec%0d_dut2_pulse", i), 32'(got[2]), 32'h1);
        chk($sformatf("vec%0d_dut0_data", i), pdat[0], vecs[i].exp0);
        chk($sformatf("vec%0d_dut1_data", i), pdat[1], vecs[i].exp1);
        chk($sformatf("vec%0d_dut2_data", i), pdat[2], vecs[i].exp2);
      end
    end

    // Back-to-back reads of the same word; model checks pulse timing and hold between pulses
    rd_en = 1'b1; rd_addr = 4'd3;
    tick(); tick();
    idle_inputs();
    for (int c = 0; c < 5; c++) tick();

    // Randomized traffic with occasional resets
    for (int c = 0; c < 400; c++) begin
      rst     = ($urandom_range(0, 199) == 0);
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 4'($urandom_range(0, 15));
      wr_data = $urandom;
      wr_be   = 4'($urandom);
      rd_en   = 1'($urandom_range(0, 1));
      rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    for (int c = 0; c < 30 && !(model_done(0) && model_done(1) && model_done(2)); c++) tick();
    chk("ready_before_flush", 32'(o_done[0] & o_done[1] & o_done[2]), 32'h1);

    // Reset with two reads in flight on the latency-3 instance
    rd_en = 1'b1; rd_addr = 4'd3;
    tick(); tick();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("flush_valid_%0d", c), 32'(o_valid[2]), 32'h0);
      chk($sformatf("flush_data_%0d", c), o_data[2], 32'h0);
    end

    // Reset at sweep count 9 restarts a full sweep
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_init("init_restart_cycles");
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
